pll_lock_sequencer: RTL and testbench



---
 rtl/pll_lock_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings up the PLLVR: holds the PLL in reset, waits for LOCK, qualifies it
//   for a run of consecutive cycles, then releases the downstream system
//   reset. A lock timeout retries the reset sequence a bounded number of
//   times before latching a sticky fault. While running, dynamic phase-shift
//   requests drive PSDA, with DUTYDA tracking half a period behind for 50% duty.
//
// Ports
//   clkin        27 MHz reference (the PLL input clock)
//   rstn         asynchronous active-low reset
//   pll_lock     PLL LOCK, asynchronous, synchronized internally
//   pll_reset    PLL RESET
//   pll_reset_p  PLL RESET_P
//   psda         PLL PSDA phase step
//   dutyda       PLL DUTYDA, (psda + 8) mod 16
//   phase_req    level request, held until phase_ack
//   phase_val    requested phase step, sampled on acceptance
//   phase_ack    one-cycle acknowledge once the new phase has settled
//   sys_rst_n    active-low reset for the PLL output domain (consumer syncs)
//   locked       qualified lock status
//   fault        sticky lock failure, cleared only by rstn
//   retry_cnt    timeouts in the current sequence, saturating
//
// Build option
//   PLL_AUTO_RELOCK_EN  when defined, a lock loss while running restarts the
//                       full reset/lock sequence; otherwise it is a fault.

module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 32,     // >= 2
  parameter int LOCK_STABLE  = 256,    // >= 2
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY    = 3,
  parameter int PSDA_SETTLE  = 16
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  input  logic       phase_req,
  input  logic [3:0] phase_val,
  output logic       phase_ack,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [1:0] retry_cnt
);

  localparam int MAX_A   = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_B   = (LOCK_TIMEOUT > PSDA_SETTLE) ? LOCK_TIMEOUT : PSDA_SETTLE;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  // The WAIT_LOCK cycle that first sees lock_s=1 is the first qualified
  // cycle, so STABLE itself only has to cover LOCK_STABLE-1 more.
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 2);
  localparam logic [CW-1:0] SET_LAST = CW'(PSDA_SETTLE - 1);
  localparam logic [1:0]    MAX_R    = (MAX_RETRY > 3) ? 2'd3 : 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_PHASE,
    S_FAULT
  } state_t;

`ifdef PLL_AUTO_RELOCK_EN
  localparam state_t LOSS_STATE = S_RESET;
`else
  localparam state_t LOSS_STATE = S_FAULT;
`endif

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    retry_n;
  logic [3:0]    psda_n, dutyda_n;
  logic          ack_n;
  logic          lock_m, lock_s;

  // Two-flop synchronizer for the asynchronous PLL LOCK.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_n  = state;
    retry_n  = retry_cnt;
    psda_n   = psda;
    dutyda_n = dutyda;
    ack_n    = 1'b0;
    case (state)
      S_RESET: begin
        if (cnt == RST_LAST) state_n = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt == TMO_LAST) begin
          if (retry_cnt == MAX_R) begin
            state_n = S_FAULT;
          end else begin
            state_n = S_RESET;
            if (retry_cnt != 2'd3) retry_n = retry_cnt + 2'd1;
          end
        end
      end
      S_STABLE: begin
        // A dropout goes back to waiting with a fresh timeout; it is not
        // counted as a retry.
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          state_n = S_RUN;
          retry_n = '0;
        end
      end
      S_RUN: begin
        // Lock loss takes priority over a coincident phase request.
        if (!lock_s) begin
          state_n = LOSS_STATE;
          retry_n = '0;
        end else if (phase_req && !phase_ack) begin
          psda_n   = phase_val;
          dutyda_n = phase_val + 4'd8;
          state_n  = S_PHASE;
        end
      end
      S_PHASE: begin
        // An in-flight request is dropped silently on lock loss.
        if (!lock_s) begin
          state_n = LOSS_STATE;
          retry_n = '0;
        end else if (cnt == SET_LAST) begin
          ack_n   = 1'b1;
          state_n = S_RUN;
        end
      end
      S_FAULT: begin
        state_n = S_FAULT;
      end
      default: begin
        state_n = S_FAULT;
      end
    endcase
  end

  // Counter clears on any state change; only counting states advance it.
  always_comb begin
    cnt_n = '0;
    if (state_n == state &&
        (state == S_RESET || state == S_WAIT_LOCK ||
         state == S_STABLE || state == S_PHASE))
      cnt_n = cnt + CW'(1);
  end

  // Outputs are registered from the next state so they change on the entry
  // edge of the state that owns them.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state       <= S_RESET;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      pll_reset_p <= 1'b1;
      psda        <= 4'd0;
      dutyda      <= 4'd8;
      sys_rst_n   <= 1'b0;
      locked      <= 1'b0;
      fault       <= 1'b0;
      phase_ack   <= 1'b0;
      retry_cnt   <= 2'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      psda        <= psda_n;
      dutyda      <= dutyda_n;
      phase_ack   <= ack_n;
      retry_cnt   <= retry_n;
      pll_reset   <= (state_n == S_RESET) || (state_n == S_FAULT);
      pll_reset_p <= (state_n == S_RESET) || (state_n == S_FAULT);
      sys_rst_n   <= (state_n == S_RUN) || (state_n == S_PHASE);
      locked      <= (state_n == S_RUN) || (state_n == S_PHASE);
      fault       <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer. The stimulus thread schedules directed
// inputs and pushes every output transition it expects (signal, value, clock
// index) into a queue; a monitor watches the outputs on each falling edge and
// matches every observed transition against that queue.

module tb_pll_lock_sequencer;

  logic       clkin = 1'b0;
  logic       rstn;
  logic       pll_lock;
  logic       pll_reset, pll_reset_p;
  logic [3:0] psda, dutyda;
  logic       phase_req;
  logic [3:0] phase_val;
  logic       phase_ack, sys_rst_n, locked, fault;
  logic [1:0] retry_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(20),
    .MAX_RETRY(2), .PSDA_SETTLE(3)
  ) dut (
    .clkin(clkin), .rstn(rstn), .pll_lock(pll_lock),
    .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
    .psda(psda), .dutyda(dutyda),
    .phase_req(phase_req), .phase_val(phase_val), .phase_ack(phase_ack),
    .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault),
    .retry_cnt(retry_cnt)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  localparam int K_RST = 0, K_RSTP = 1, K_SRST = 2, K_LOCK = 3, K_FLT = 4,
                 K_RTY = 5, K_ACK = 6, K_PSDA = 7, K_DUTY = 8, NK = 9;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  prev [NK];
  int  cur  [NK];

  function automatic string kname(input int k);
    case (k)
      K_RST:   return "pll_reset";
      K_RSTP:  return "pll_reset_p";
      K_SRST:  return "sys_rst_n";
      K_LOCK:  return "locked";
      K_FLT:   return "fault";
      K_RTY:   return "retry_cnt";
      K_ACK:   return "phase_ack";
      K_PSDA:  return "psda";
      default: return "dutyda";
    endcase
  endfunction

  task automatic expect_ev(input int k, input int v, input int c);
    exp_q.push_back('{k, v, c});
  endtask

  task automatic got_event(input int k, input int v);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (idx < 0 && exp_q[i].kind == k) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL %s: changed to %0d at cycle %0d, no change required",
               kname(k), v, cyc);
    end else begin
      if (exp_q[idx].val != v || exp_q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                 kname(k), v, cyc, exp_q[idx].val, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  // Monitor: any output transition while out of reset is an event.
  always @(negedge clkin) begin
    cur[K_RST]  = int'(pll_reset);
    cur[K_RSTP] = int'(pll_reset_p);
    cur[K_SRST] = int'(sys_rst_n);
    cur[K_LOCK] = int'(locked);
    cur[K_FLT]  = int'(fault);
    cur[K_RTY]  = int'(retry_cnt);
    cur[K_ACK]  = int'(phase_ack);
    cur[K_PSDA] = int'(psda);
    cur[K_DUTY] = int'(dutyda);
    for (int k = 0; k < NK; k++) begin
      if (rstn && cur[k] != prev[k]) got_event(k, cur[k]);
      prev[k] = cur[k];
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic check_reset_state();
    chk("rst pll_reset", int'(pll_reset), 1);
    chk("rst pll_reset_p", int'(pll_reset_p), 1);
    chk("rst psda", int'(psda), 0);
    chk("rst dutyda", int'(dutyda), 8);
    chk("rst sys_rst_n", int'(sys_rst_n), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst fault", int'(fault), 0);
    chk("rst phase_ack", int'(phase_ack), 0);
    chk("rst retry_cnt", int'(retry_cnt), 0);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge clkin);
  endtask

  task automatic rst_assert();
    @(negedge clkin);
    #1 rstn = 1'b0;
    pll_lock  = 1'b0;
    phase_req = 1'b0;
    #1 check_reset_state();
  endtask

  // Release reset; PLL reset drops after 4 cycles.
  task automatic rel(output int r);
    @(negedge clkin);
    r = cyc;
    #1 rstn = 1'b1;
    expect_ev(K_RST, 0, r + 4);
    expect_ev(K_RSTP, 0, r + 4);
  endtask

  // Raise lock at cycle n: 2 sync cycles + 8 qualified cycles to release.
  task automatic bring_up(input int n);
    at(n);
    pll_lock = 1'b1;
    expect_ev(K_SRST, 1, n + 10);
    expect_ev(K_LOCK, 1, n + 10);
  endtask

  task automatic phase_xact(input int p, input int v, input int dv, input int drop);
    at(p);
    phase_req = 1'b1;
    phase_val = 4'(v);
    expect_ev(K_PSDA, v, p + 1);
    expect_ev(K_DUTY, dv, p + 1);
    expect_ev(K_ACK, 1, p + 4);
    expect_ev(K_ACK, 0, p + 5);
    at(p + drop);
    phase_req = 1'b0;
  endtask

  // Lock dropped at cycle l: effect lands 3 cycles later.
  task automatic lock_loss(input int l);
    at(l);
    pll_lock = 1'b0;
    expect_ev(K_SRST, 0, l + 3);
    expect_ev(K_LOCK, 0, l + 3);
    expect_ev(K_RST, 1, l + 3);
    expect_ev(K_RSTP, 1, l + 3);
`ifdef PLL_AUTO_RELOCK_EN
    expect_ev(K_RST, 0, l + 7);
    expect_ev(K_RSTP, 0, l + 7);
`else
    expect_ev(K_FLT, 1, l + 3);
`endif
  endtask

  initial begin
    int r, n, p, l;
    rstn      = 1'b0;
    pll_lock  = 1'b0;
    phase_req = 1'b0;
    phase_val = 4'd0;
    repeat (3) @(negedge clkin);
    #1 check_reset_state();

    // 1: nominal bring-up
    rel(r);
    bring_up(r + 9);
    at(r + 20);
    chk("bringup retry_cnt", int'(retry_cnt), 0);

    // 4: phase changes; request held through the first ack cycle
    phase_xact(r + 22, 3, 11, 5);
    phase_xact(r + 29, 12, 4, 4);

    // 6: phase request coincides with lock_s falling
    n = r + 36;
    lock_loss(n);
    at(n + 2);
    phase_req = 1'b1;
    phase_val = 4'd7;
    at(n + 4);
    phase_req = 1'b0;
`ifdef PLL_AUTO_RELOCK_EN
    bring_up(n + 8);
    at(n + 20);
`else
    at(n + 8);
`endif
    chk("collide psda", int'(psda), 12);
    chk("collide dutyda", int'(dutyda), 4);

    // 2: one-cycle lock glitch after 5 qualified cycles
    rst_assert();
    rel(r);
    n = r + 9;
    at(n);
    pll_lock = 1'b1;
    at(n + 5);
    pll_lock = 1'b0;
    at(n + 6);
    pll_lock = 1'b1;
    expect_ev(K_SRST, 1, n + 16);
    expect_ev(K_LOCK, 1, n + 16);
    at(n + 18);
    chk("glitch retry_cnt", int'(retry_cnt), 0);

    // 5: lock loss in RUN
    p = n + 18;
    phase_xact(p, 5, 13, 4);
    l = p + 7;
    lock_loss(l);
`ifdef PLL_AUTO_RELOCK_EN
    bring_up(l + 8);
    at(l + 20);
    chk("relock locked", int'(locked), 1);
`else
    at(l + 8);
    chk("loss fault", int'(fault), 1);
`endif
    chk("loss psda kept", int'(psda), 5);
    chk("loss dutyda kept", int'(dutyda), 13);

    // 3: timeouts and fault
    rst_assert();
    rel(r);
    expect_ev(K_RST, 1, r + 24);  expect_ev(K_RSTP, 1, r + 24);
    expect_ev(K_RTY, 1, r + 24);
    expect_ev(K_RST, 0, r + 28);  expect_ev(K_RSTP, 0, r + 28);
    expect_ev(K_RST, 1, r + 48);  expect_ev(K_RSTP, 1, r + 48);
    expect_ev(K_RTY, 2, r + 48);
    expect_ev(K_RST, 0, r + 52);  expect_ev(K_RSTP, 0, r + 52);
    expect_ev(K_RST, 1, r + 72);  expect_ev(K_RSTP, 1, r + 72);
    expect_ev(K_FLT, 1, r + 72);
    at(r + 76);
    chk("timeout fault", int'(fault), 1);
    chk("timeout pll_reset", int'(pll_reset), 1);
    chk("timeout retry_cnt", int'(retry_cnt), 2);
    chk("timeout sys_rst_n", int'(sys_rst_n), 0);
    rst_assert();

    repeat (3) @(negedge clkin);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no change seen, required %0d at cycle %0d",
               kname(exp_q[0].kind), exp_q[0].val, exp_q[0].cyc);
      exp_q.delete(0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
